ifid_pipe: RTL and testbench
============================

Name: ifid_pipe

Overview:
IF/ID pipeline register directly downstream of the fetch stage. It captures each fetched instruction and its PC+2 value, and inserts NOP bubbles while instruction memory is busy. It holds on decode hazards and DMemDump, and squashes on a taken branch or jump. It also detects HALT and fetch errors, produces the halt_err qualifier that fetch consumes, and keeps saturating instruction/bubble counters for performance debug.

Parameters:
NOP_INSTR, 16'h0800, encoding driven while no valid instruction is held
HALT_OPCODE, 5'b00000, value of instr[15:11] that marks HALT
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
instruction  input  16  instruction from fetch; already NOP when fetch is busy
increment  input  16  PC+2 from fetch
Stall  input  1  fetch memory stall
Done  input  1  fetch memory done
err  input  1  fetch memory error
IFID_Stall_in  input  1  hold request from the decode hazard unit
MemWB_DMemDump  input  1  dump in progress; freezes the front end
EXMem_take_branch_or_jump  input  1  flush for a redirect resolved in EX/MEM
IFID_instruction  output  16  registered instruction to decode
IFID_increment  output  16  registered PC+2 to decode (fetch's IFID_increment input)
IFID_valid  output  1  IFID_instruction is a real fetched instruction
IFID_halt  output  1  sticky; a HALT was latched
IFID_err  output  1  sticky; a fetch error was latched
halt_err  output  1  IFID_halt | IFID_err; combinational from state, feeds fetch
instr_count  output  CNT_W  valid instructions loaded
bubble_count  output  CNT_W  bubbles inserted because fetch was busy

Behaviour:
- Reset (rst=0, asynchronous, any cycle including mid-stall) forces these values:
  - IFID_instruction=NOP_INSTR, IFID_increment=0, IFID_valid=0
  - IFID_halt=0, IFID_err=0, both counters 0, state RUN
- Latency: 1 cycle from fetch outputs to IFID_* outputs.
- FSM states: RUN, HALTED.
- RUN, per rising edge; the first matching rule wins:
  1. Flush (EXMem_take_branch_or_jump=1): instruction<=NOP_INSTR, valid<=0, increment held.
     - Flush overrides IFID_Stall_in and DMemDump.
     - Counters unchanged.
  2. Hold (IFID_Stall_in | MemWB_DMemDump): every register keeps its value.
  3. Fetch busy (Stall | ~Done): instruction<=NOP_INSTR, valid<=0, bubble_count++.
  4. Fetch error (err=1): instruction<=NOP_INSTR, valid<=0, IFID_err<=1, state->HALTED.
  5. Load: instruction<=instruction, increment<=increment, valid<=1, instr_count++.
     - If instruction[15:11]==HALT_OPCODE, also IFID_halt<=1 and state->HALTED.
     - The HALT instruction itself is presented to decode as valid.
- HALTED:
  - Flush returns to RUN: instruction<=NOP_INSTR, valid<=0, IFID_halt<=0.
    - Covers a HALT or err fetched on the wrong path.
    - IFID_err is also cleared on this flush.
  - Without flush, all registers freeze; valid drops to 0 on the first HALTED edge.
  - Stall, err and IFID_Stall_in are ignored.
- Counters saturate at all-ones and never wrap.
- halt_err is asserted in the cycle after HALT or err is latched. Fetch forces NOP from then on.

Test Plan:
- Reset and free run:
  - Stimulus: rst=0 for 2 cycles; release with Done=1, Stall=0; feed 16'h4001/inc 16'h0002, then 16'h4102/inc 16'h0004.
  - Required: IFID_instruction=0x0800 and valid=0 before release; then 0x4001/0x0002 and 0x4102/0x0004 on consecutive cycles; instr_count=2.
- Fetch busy:
  - Stimulus: Stall=1, Done=0 for 3 cycles, then Done=1 with 16'h4203.
  - Required: three NOP 0x0800 cycles with valid=0; bubble_count=3; then 0x4203 with valid=1.
- Hold vs flush:
  - Stimulus: IFID_Stall_in=1 for 2 cycles holding 0x4001; then IFID_Stall_in=1 and EXMem_take_branch_or_jump=1 in the same cycle.
  - Required: 0x4001 held for 2 cycles; the flush cycle yields 0x0800 with valid=0; increment unchanged.
- HALT:
  - Stimulus: feed 16'h0000.
  - Required: valid=1 with 0x0000 for one cycle; IFID_halt=1 and halt_err=1; subsequent inputs ignored; instr_count stops.
- Wrong-path HALT:
  - Stimulus: after HALT latches, pulse EXMem_take_branch_or_jump=1.
  - Required: IFID_halt=0, state RUN, next fetched instruction loads normally.
- Error and mid-stall reset:
  - Stimulus: err=1 with Done=1; later assert rst=0 mid-hold.
  - Required: IFID_err=1 and halt_err=1; reset clears all outputs asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/ifid_pipe.sv
// IF/ID pipeline register.
// Captures the fetched instruction and its PC+2, and inserts NOP bubbles while
// instruction memory is busy. It holds for decode hazards and data-memory dumps,
// and squashes on a redirect. It latches HALT and fetch errors into a sticky
// HALTED state and keeps saturating instruction and bubble counters for
// performance debug.
module ifid_pipe #(
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instruction,
  input  logic [15:0]      increment,
  input  logic             Stall,
  input  logic             Done,
  input  logic             err,
  input  logic             IFID_Stall_in,
  input  logic             MemWB_DMemDump,
  input  logic             EXMem_take_branch_or_jump,
  output logic [15:0]      IFID_instruction,
  output logic [15:0]      IFID_increment,
  output logic             IFID_valid,
  output logic             IFID_halt,
  output logic             IFID_err,
  output logic             halt_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [15:0]      inc_q, inc_d;
  logic             valid_q, valid_d;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic flush_s;
  logic hold_s;
  logic busy_s;

  assign flush_s = EXMem_take_branch_or_jump;
  assign hold_s  = IFID_Stall_in | MemWB_DMemDump;
  assign busy_s  = Stall | ~Done;

  // Next-state selection; the first matching rule in RUN wins.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    inc_d   = inc_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    err_d   = err_q;
    icnt_d  = icnt_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush_s) begin
          // Redirect squashes the slot; PC+2 is kept so decode sees a stable value.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (hold_s) begin
          // Everything keeps its value.
          state_d = state_q;
        end else if (busy_s) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          bcnt_d  = sat_inc(bcnt_q);
        end else if (err) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          instr_d = instruction;
          inc_d   = increment;
          valid_d = 1'b1;
          icnt_d  = sat_inc(icnt_q);
          if (instruction[15:11] == HALT_OPCODE) begin
            // HALT still reaches decode as a valid instruction.
            halt_d  = 1'b1;
            state_d = ST_HALTED;
          end else begin
            halt_d  = halt_q;
          end
        end
      end
      ST_HALTED: begin
        if (flush_s) begin
          // HALT/err came from the wrong path: resume fetching.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          halt_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      instr_q <= NOP_INSTR;
      inc_q   <= 16'h0000;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      icnt_q  <= {CNT_W{1'b0}};
      bcnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      inc_q   <= inc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign IFID_instruction = instr_q;
  assign IFID_increment   = inc_q;
  assign IFID_valid       = valid_q;
  assign IFID_halt        = halt_q;
  assign IFID_err         = err_q;
  assign halt_err         = halt_q | err_q;
  assign instr_count      = icnt_q;
  assign bubble_count     = bcnt_q;

endmodule

// File: tb/tb_ifid_pipe.sv
// Directed bench for ifid_pipe: each task drives one scenario and checks
// hand-computed expected values one time unit after the active edge.
module tb_ifid_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [15:0] increment;
  logic        Stall;
  logic        Done;
  logic        err;
  logic        IFID_Stall_in;
  logic        MemWB_DMemDump;
  logic        EXMem_take_branch_or_jump;
  logic [15:0] IFID_instruction;
  logic [15:0] IFID_increment;
  logic        IFID_valid;
  logic        IFID_halt;
  logic        IFID_err;
  logic        halt_err;
  logic [15:0] instr_count;
  logic [15:0] bubble_count;

  int vectors;
  int miscompares;

  ifid_pipe dut (
    .clk                       (clk),
    .rst                       (rst),
    .instruction               (instruction),
    .increment                 (increment),
    .Stall                     (Stall),
    .Done                      (Done),
    .err                       (err),
    .IFID_Stall_in             (IFID_Stall_in),
    .MemWB_DMemDump            (MemWB_DMemDump),
    .EXMem_take_branch_or_jump (EXMem_take_branch_or_jump),
    .IFID_instruction          (IFID_instruction),
    .IFID_increment            (IFID_increment),
    .IFID_valid                (IFID_valid),
    .IFID_halt                 (IFID_halt),
    .IFID_err                  (IFID_err),
    .halt_err                  (halt_err),
    .instr_count               (instr_count),
    .bubble_count              (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instruction = 16'h4001; increment = 16'h0002;
    Stall = 1'b0; Done = 1'b1; err = 1'b0;
    IFID_Stall_in = 1'b0; MemWB_DMemDump = 1'b0; EXMem_take_branch_or_jump = 1'b0;
    step();
    step();
    vectors++;
    if (IFID_instruction !== 16'h0800) begin miscompares++; $display("FAIL reset_instr got %h want 0800", IFID_instruction); end
    vectors++;
    if (IFID_valid !== 1'b0 || IFID_increment !== 16'h0000) begin miscompares++; $display("FAIL reset_valid_inc got %b/%h want 0/0000", IFID_valid, IFID_increment); end
    vectors++;
    if (IFID_halt !== 1'b0 || IFID_err !== 1'b0 || halt_err !== 1'b0 || instr_count !== 16'd0 || bubble_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_flags got h%b e%b he%b ic%0d bc%0d want all 0", IFID_halt, IFID_err, halt_err, instr_count, bubble_count);
    end
  endtask

  task automatic test_free_run();
    rst = 1'b1;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4001 || IFID_increment !== 16'h0002 || IFID_valid !== 1'b1) begin
      miscompares++; $display("FAIL run_first got %h/%h/%b want 4001/0002/1", IFID_instruction, IFID_increment, IFID_valid);
    end
    instruction = 16'h4102; increment = 16'h0004;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4102 || IFID_increment !== 16'h0004 || IFID_valid !== 1'b1) begin
      miscompares++; $display("FAIL run_second got %h/%h/%b want 4102/0004/1", IFID_instruction, IFID_increment, IFID_valid);
    end
    vectors++;
    if (instr_count !== 16'd2) begin miscompares++; $display("FAIL run_count got %0d want 2", instr_count); end
  endtask

  task automatic test_fetch_busy();
    Stall = 1'b1; Done = 1'b0; instruction = 16'h0800; increment = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (IFID_instruction !== 16'h0800 || IFID_valid !== 1'b0 || bubble_count !== 16'(i + 1)) begin
        miscompares++; $display("FAIL busy_bubble%0d got %h/%b/%0d want 0800/0/%0d", i, IFID_instruction, IFID_valid, bubble_count, i + 1);
      end
    end
    vectors++;
    if (IFID_increment !== 16'h0004 || instr_count !== 16'd2) begin
      miscompares++; $display("FAIL busy_held got %h/%0d want 0004/2", IFID_increment, instr_count);
    end
    Stall = 1'b0; Done = 1'b1; instruction = 16'h4203; increment = 16'h0006;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4203 || IFID_valid !== 1'b1 || IFID_increment !== 16'h0006 || instr_count !== 16'd3 || bubble_count !== 16'd3) begin
      miscompares++; $display("FAIL busy_resume got %h/%b/%h/%0d/%0d want 4203/1/0006/3/3", IFID_instruction, IFID_valid, IFID_increment, instr_count, bubble_count);
    end
  endtask

  task automatic test_hold_flush();
    instruction = 16'h4001; increment = 16'h0008;
    step();
    instruction = 16'h4444; increment = 16'h000A;
    IFID_Stall_in = 1'b1;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4001 || IFID_valid !== 1'b1 || IFID_increment !== 16'h0008) begin
      miscompares++; $display("FAIL hold_stall got %h/%b/%h want 4001/1/0008", IFID_instruction, IFID_valid, IFID_increment);
    end
    IFID_Stall_in = 1'b0; MemWB_DMemDump = 1'b1;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4001 || IFID_valid !== 1'b1 || instr_count !== 16'd4) begin
      miscompares++; $display("FAIL hold_dump got %h/%b/%0d want 4001/1/4", IFID_instruction, IFID_valid, instr_count);
    end
    IFID_Stall_in = 1'b1; EXMem_take_branch_or_jump = 1'b1;
    step();
    vectors++;
    if (IFID_instruction !== 16'h0800 || IFID_valid !== 1'b0 || IFID_increment !== 16'h0008 || instr_count !== 16'd4 || bubble_count !== 16'd3) begin
      miscompares++; $display("FAIL flush_over_hold got %h/%b/%h/%0d/%0d want 0800/0/0008/4/3", IFID_instruction, IFID_valid, IFID_increment, instr_count, bubble_count);
    end
    IFID_Stall_in = 1'b0; MemWB_DMemDump = 1'b0; EXMem_take_branch_or_jump = 1'b0;
  endtask

  task automatic test_halt();
    instruction = 16'h0000; increment = 16'h000C;
    step();
    vectors++;
    if (IFID_instruction !== 16'h0000 || IFID_valid !== 1'b1 || IFID_halt !== 1'b1 || halt_err !== 1'b1 || instr_count !== 16'd5) begin
      miscompares++; $display("FAIL halt_load got %h/%b/%b/%b/%0d want 0000/1/1/1/5", IFID_instruction, IFID_valid, IFID_halt, halt_err, instr_count);
    end
    instruction = 16'h4555; increment = 16'h000E; err = 1'b1;
    step();
    step();
    vectors++;
    if (IFID_instruction !== 16'h0000 || IFID_valid !== 1'b0 || IFID_increment !== 16'h000C || instr_count !== 16'd5 || IFID_err !== 1'b0) begin
      miscompares++; $display("FAIL halt_frozen got %h/%b/%h/%0d/%b want 0000/0/000C/5/0", IFID_instruction, IFID_valid, IFID_increment, instr_count, IFID_err);
    end
    err = 1'b0;
  endtask

  task automatic test_wrong_path_halt();
    EXMem_take_branch_or_jump = 1'b1;
    step();
    vectors++;
    if (IFID_halt !== 1'b0 || halt_err !== 1'b0 || IFID_instruction !== 16'h0800 || IFID_valid !== 1'b0) begin
      miscompares++; $display("FAIL wrongpath_clear got %b/%b/%h/%b want 0/0/0800/0", IFID_halt, halt_err, IFID_instruction, IFID_valid);
    end
    EXMem_take_branch_or_jump = 1'b0;
    instruction = 16'h4666; increment = 16'h0010;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4666 || IFID_increment !== 16'h0010 || IFID_valid !== 1'b1 || instr_count !== 16'd6) begin
      miscompares++; $display("FAIL wrongpath_resume got %h/%h/%b/%0d want 4666/0010/1/6", IFID_instruction, IFID_increment, IFID_valid, instr_count);
    end
  endtask

  task automatic test_err_and_reset();
    err = 1'b1; Done = 1'b1; instruction = 16'h4777; increment = 16'h0012;
    step();
    vectors++;
    if (IFID_err !== 1'b1 || halt_err !== 1'b1 || IFID_halt !== 1'b0 || IFID_instruction !== 16'h0800 || IFID_valid !== 1'b0 || instr_count !== 16'd6) begin
      miscompares++; $display("FAIL err_latch got e%b he%b h%b %h v%b ic%0d want 1/1/0/0800/0/6", IFID_err, halt_err, IFID_halt, IFID_instruction, IFID_valid, instr_count);
    end
    err = 1'b0; IFID_Stall_in = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (IFID_instruction !== 16'h0800 || IFID_increment !== 16'h0000 || IFID_valid !== 1'b0 || IFID_err !== 1'b0 || halt_err !== 1'b0 || instr_count !== 16'd0 || bubble_count !== 16'd0) begin
      miscompares++; $display("FAIL async_reset got %h/%h/%b/%b/%b/%0d/%0d want 0800/0000/0/0/0/0/0", IFID_instruction, IFID_increment, IFID_valid, IFID_err, halt_err, instr_count, bubble_count);
    end
    IFID_Stall_in = 1'b0;
    step();
    rst = 1'b1;
    instruction = 16'h4888; increment = 16'h0014;
    step();
    vectors++;
    if (IFID_instruction !== 16'h4888 || IFID_valid !== 1'b1 || instr_count !== 16'd1) begin
      miscompares++; $display("FAIL post_reset_load got %h/%b/%0d want 4888/1/1", IFID_instruction, IFID_valid, instr_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_free_run();
    test_fetch_busy();
    test_hold_flush();
    test_halt();
    test_wrong_path_halt();
    test_err_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
